// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned STALL_W = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_bubble;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0};
   localparam hz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                       ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0};
   localparam hz_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                      ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1};
   localparam hz_ctrl_t CTRL_LU = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                    ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_bubble: 1'b0};

   // Load in EX whose non-zero destination feeds a source read by the ID instruction.
   function automatic logic load_use(input logic             mem_read,
                                     input logic [REG_W-1:0] ex_rt,
                                     input logic [REG_W-1:0] id_rs,
                                     input logic [REG_W-1:0] id_rt,
                                     input logic             uses_rt);
      return mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
   import pipe_hazard_ctrl_pkg::*;

   logic               IDEX_MemRead;
   logic [REG_W-1:0]   IDEX_Rt;
   logic [REG_W-1:0]   IFID_Rs;
   logic [REG_W-1:0]   IFID_Rt;
   logic               IFID_UsesRt;
   logic               Branch_Taken;
   logic               Mul_Start;

   logic               PC_Write;
   logic               IFID_Write;
   logic               IDEX_Write;
   logic               IFID_Flush;
   logic               IDEX_Bubble;
   logic               EXMEM_Bubble;
   logic               Mul_Busy;
   logic [STALL_W-1:0] Stall_Cnt;

   // Datapath side: reports pipeline contents, consumes enables.
   modport master (
      output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, Branch_Taken, Mul_Start,
      input  PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble,
             Mul_Busy, Stall_Cnt
   );

   // Controller side.
   modport slave (
      input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, Branch_Taken, Mul_Start,
      output PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble,
             Mul_Busy, Stall_Cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle EX holds, with a saturating count of PC-stall cycles.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 4
) (
   input logic               Clk,
   input logic               Rst,
   pipe_hazard_ctrl_if.slave hz
);

   // Counter preload: one hold is spent in RUN, one release cycle ends MUL_BUSY.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

   state_e             state_q;
   state_e             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   hz_ctrl_t           ctrl;
   logic               lu;
   logic [STALL_W-1:0] stall_cnt;

   assign lu = load_use(hz.IDEX_MemRead, hz.IDEX_Rt, hz.IFID_Rs, hz.IFID_Rt, hz.IFID_UsesRt);

   // Next state and same-cycle control outputs; reset forces the defaults.
   always_comb begin
      ctrl    = CTRL_RUN;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!Rst) begin
         case (state_q)
            RUN: begin
               if (hz.Branch_Taken) begin
                  ctrl = CTRL_FLUSH;
               end else if (hz.Mul_Start) begin
                  ctrl    = CTRL_HOLD;
                  state_d = MUL_BUSY;
                  cnt_d   = CNT_LOAD;
               end else if (lu) begin
                  ctrl = CTRL_LU;
               end
            end
            MUL_BUSY: begin
               if (cnt_q != '0) begin
                  ctrl  = CTRL_HOLD;
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   sat_counter #(
      .WIDTH (STALL_W)
   ) u_stall_cnt (
      .clk     (Clk),
      .rst     (Rst),
      .inc_i   (!ctrl.pc_write),
      .count_o (stall_cnt)
   );

   assign hz.PC_Write     = ctrl.pc_write;
   assign hz.IFID_Write   = ctrl.ifid_write;
   assign hz.IDEX_Write   = ctrl.idex_write;
   assign hz.IFID_Flush   = ctrl.ifid_flush;
   assign hz.IDEX_Bubble  = ctrl.idex_bubble;
   assign hz.EXMEM_Bubble = ctrl.exmem_bubble;
   assign hz.Mul_Busy     = !Rst && (state_q == MUL_BUSY);
   assign hz.Stall_Cnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random cycles
// checked against a cycle-count model of the hazard rules.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int unsigned LAT = 4;

   // Output vector order: PC_Write IFID_Write IDEX_Write IFID_Flush IDEX_Bubble EXMEM_Bubble Mul_Busy
   localparam logic [6:0] V_DEF   = 7'b1110000;
   localparam logic [6:0] V_FLUSH = 7'b1111100;
   localparam logic [6:0] V_START = 7'b0000010;
   localparam logic [6:0] V_LU    = 7'b0010100;
   localparam logic [6:0] V_HOLD  = 7'b0000011;
   localparam logic [6:0] V_REL   = 7'b1110001;

   typedef struct packed {
      logic       rst;
      logic       memread;
      logic [4:0] ex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       br;
      logic       ms;
   } stim_t;

   logic Clk = 1'b0;
   logic Rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_busy_left = 0;   // MUL_BUSY cycles still to come in the model
   int   m_stall = 0;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.MUL_LAT(LAT)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .hz  (hz)
   );

   always #5 Clk = ~Clk;

   task automatic drive(input stim_t s);
      Rst             = s.rst;
      hz.IDEX_MemRead = s.memread;
      hz.IDEX_Rt      = s.ex_rt;
      hz.IFID_Rs      = s.rs;
      hz.IFID_Rt      = s.rt;
      hz.IFID_UsesRt  = s.uses_rt;
      hz.Branch_Taken = s.br;
      hz.Mul_Start    = s.ms;
   endtask

   function automatic logic [6:0] obs();
      return {hz.PC_Write, hz.IFID_Write, hz.IDEX_Write, hz.IFID_Flush,
              hz.IDEX_Bubble, hz.EXMEM_Bubble, hz.Mul_Busy};
   endfunction

   function automatic logic [6:0] model_out(input stim_t s);
      bit lu;
      lu = s.memread && (s.ex_rt != 0) &&
           ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
      if (s.rst) return V_DEF;
      if (m_busy_left > 0) return (m_busy_left > 1) ? V_HOLD : V_REL;
      if (s.br) return V_FLUSH;
      if (s.ms) return V_START;
      if (lu) return V_LU;
      return V_DEF;
   endfunction

   function automatic void model_step(input stim_t s);
      logic [6:0] o;
      o = model_out(s);
      if (s.rst) begin
         m_busy_left = 0;
         m_stall     = 0;
         return;
      end
      if (!o[6] && m_stall < 65535) m_stall++;
      if (m_busy_left > 0) m_busy_left--;
      else if (!s.br && s.ms) m_busy_left = LAT - 1;
   endfunction

   function automatic stim_t rand_stim(input bit allow_rst);
      stim_t s;
      s.rst     = allow_rst && ($urandom_range(0, 39) == 0);
      s.memread = 1'($urandom_range(0, 1));
      s.ex_rt   = 5'($urandom_range(0, 3));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.br      = ($urandom_range(0, 7) == 0);
      s.ms      = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   task automatic test_reset();
      stim_t s;
      for (int i = 0; i < 4; i++) begin
         s = rand_stim(1'b0);
         s.rst = 1'b1;
         @(negedge Clk); drive(s); #1;
         n_tests++;
         if (obs() !== V_DEF || hz.Stall_Cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset cyc%0d got=%b/%0d want=%b/0", i, obs(), hz.Stall_Cnt, V_DEF);
         end
         model_step(s);
      end
   endtask

   task automatic test_load_use();
      stim_t s = '0;
      s.memread = 1'b1; s.ex_rt = 5'd8; s.rs = 5'd8; s.rt = 5'd3;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_LU) begin
         n_fail++;
         $display("FAIL load_use got=%b want=%b", obs(), V_LU);
      end
      model_step(s);
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_DEF || hz.Stall_Cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_after got=%b/%0d want=%b/1", obs(), hz.Stall_Cnt, V_DEF);
      end
      model_step(s);
   endtask

   task automatic test_rt_zero();
      stim_t s = '0;
      s.memread = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.uses_rt = 1'b1;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_DEF) begin
         n_fail++;
         $display("FAIL rt_zero got=%b want=%b", obs(), V_DEF);
      end
      model_step(s);
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (hz.Stall_Cnt !== 16'(m_stall)) begin
         n_fail++;
         $display("FAIL rt_zero_cnt got=%0d want=%0d", hz.Stall_Cnt, m_stall);
      end
      model_step(s);
   endtask

   task automatic test_mul();
      logic [6:0] want [5] = '{V_START, V_HOLD, V_HOLD, V_REL, V_DEF};
      stim_t s;
      int base;
      int holds = 0;
      int busys = 0;
      base = m_stall;
      for (int i = 0; i < 5; i++) begin
         // Hazard inputs during MUL_BUSY are noise that must be ignored.
         s = (i == 0) ? stim_t'('0) : rand_stim(1'b0);
         if (i == 0) s.ms = 1'b1;
         if (i == 4) s = '0;
         @(negedge Clk); drive(s); #1;
         if (hz.EXMEM_Bubble === 1'b1 && hz.PC_Write === 1'b0) holds++;
         if (hz.Mul_Busy === 1'b1) busys++;
         n_tests++;
         if (obs() !== want[i]) begin
            n_fail++;
            $display("FAIL mul cyc%0d got=%b want=%b", i, obs(), want[i]);
         end
         model_step(s);
      end
      n_tests++;
      if (holds != 3 || busys != 3 || hz.Stall_Cnt !== 16'(base + 3)) begin
         n_fail++;
         $display("FAIL mul_totals holds=%0d busy=%0d cnt=%0d want 3/3/%0d",
                  holds, busys, hz.Stall_Cnt, base + 3);
      end
   endtask

   task automatic test_priority();
      stim_t s = '0;
      s.br = 1'b1; s.ms = 1'b1; s.memread = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_FLUSH) begin
         n_fail++;
         $display("FAIL priority got=%b want=%b", obs(), V_FLUSH);
      end
      model_step(s);
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_DEF) begin
         n_fail++;
         $display("FAIL priority_after got=%b want=%b", obs(), V_DEF);
      end
      model_step(s);
   endtask

   task automatic test_reset_in_mul();
      stim_t s = '0;
      s.ms = 1'b1;
      @(negedge Clk); drive(s); #1; model_step(s);
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_HOLD) begin
         n_fail++;
         $display("FAIL rst_mul_busy1 got=%b want=%b", obs(), V_HOLD);
      end
      model_step(s);
      s = '0; s.rst = 1'b1; s.ms = 1'b1; s.br = 1'b1;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_DEF) begin
         n_fail++;
         $display("FAIL rst_mul_during got=%b want=%b", obs(), V_DEF);
      end
      model_step(s);
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (obs() !== V_DEF || hz.Stall_Cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_mul_after got=%b/%0d want=%b/0", obs(), hz.Stall_Cnt, V_DEF);
      end
      model_step(s);
   endtask

   task automatic test_random();
      stim_t s;
      logic [6:0] exp;
      for (int i = 0; i < 400; i++) begin
         s = rand_stim(1'b1);
         @(negedge Clk); drive(s); #1;
         exp = model_out(s);
         n_tests++;
         if (obs() !== exp || hz.Stall_Cnt !== 16'(m_stall)) begin
            n_fail++;
            $display("FAIL random cyc%0d got=%b/%0d want=%b/%0d",
                     i, obs(), hz.Stall_Cnt, exp, m_stall);
         end
         model_step(s);
      end
   endtask

   task automatic test_saturation();
      stim_t s = '0;
      s.rst = 1'b1;
      @(negedge Clk); drive(s); #1; model_step(s);
      s = '0;
      s.memread = 1'b1; s.ex_rt = 5'd9; s.rt = 5'd9; s.uses_rt = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         @(negedge Clk); drive(s); #1; model_step(s);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk); drive(s); #1;
         n_tests++;
         if (obs() !== V_LU || hz.Stall_Cnt !== ((i == 0) ? 16'hFFFE : 16'hFFFF)) begin
            n_fail++;
            $display("FAIL saturate cyc%0d got=%b/%h want=%b/%h", i, obs(), hz.Stall_Cnt,
                     V_LU, (i == 0) ? 16'hFFFE : 16'hFFFF);
         end
         model_step(s);
      end
      s = '0;
      @(negedge Clk); drive(s); #1;
      n_tests++;
      if (hz.Stall_Cnt !== 16'hFFFF || hz.Stall_Cnt !== 16'(m_stall)) begin
         n_fail++;
         $display("FAIL saturate_final got=%h want=FFFF", hz.Stall_Cnt);
      end
      model_step(s);
   endtask

   initial begin
      stim_t s0 = '0;
      s0.rst = 1'b1;
      drive(s0);
      @(posedge Clk);
      model_step(s0);
      test_reset();
      test_load_use();
      test_rt_zero();
      test_mul();
      test_priority();
      test_reset_in_mul();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: total EX-stage occupancy of a multi-cycle instruction, in cycles; legal range 2..16.
REQ-002 SHALL have port Clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port IDEX_MemRead  input  1: the instruction in EX is a load.
REQ-005 SHALL have port IDEX_Rt  input  5: destination register of the instruction in EX.
REQ-006 SHALL have ports IFID_Rs and IFID_Rt  input  5 each: source registers of the instruction in ID.
REQ-007 SHALL have port IFID_UsesRt  input  1: the ID instruction reads Rt.
REQ-008 SHALL have port Branch_Taken  input  1: branch resolved taken in EX this cycle.
REQ-009 SHALL have port Mul_Start  input  1: the instruction in EX is multi-cycle.
REQ-010 SHALL have ports PC_Write, IFID_Write and IDEX_Write  output  1 each: pipeline-register write enables.
REQ-011 SHALL have port IFID_Flush  output  1: zero the IF/ID register on the next edge.
REQ-012 SHALL have port IDEX_Bubble  output  1: load zero WB/MEM/EX control into ID/EX.
REQ-013 SHALL have port EXMEM_Bubble  output  1: load zero control into EX/MEM.
REQ-014 SHALL have port Mul_Busy  output  1: high while the FSM is in MUL_BUSY.
REQ-015 SHALL have port Stall_Cnt  output  16: saturating count of cycles with PC_Write=0.

Function
REQ-016 SHALL implement a two-state FSM (RUN, MUL_BUSY) plus a 4-bit down-counter Cnt; all control outputs SHALL be Mealy (same-cycle) functions of state, Cnt and inputs.
REQ-017 SHALL default the outputs to PC_Write=IFID_Write=IDEX_Write=1 and IFID_Flush=IDEX_Bubble=EXMEM_Bubble=0.
REQ-018 SHALL define the load-use hazard LU as IDEX_MemRead & (IDEX_Rt!=0) & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
REQ-019 SHALL, in RUN, apply input priority Branch_Taken > Mul_Start > LU.
REQ-020 SHALL, in RUN with Branch_Taken, drive IFID_Flush=1 and IDEX_Bubble=1, keep PC_Write=1, and stay in RUN.
REQ-021 SHALL, in RUN with Mul_Start (no branch), drive PC_Write=IFID_Write=IDEX_Write=0 and EXMEM_Bubble=1, go to MUL_BUSY, and load Cnt with MUL_LAT-2.
REQ-022 SHALL, in RUN with LU only, drive PC_Write=IFID_Write=0 and IDEX_Bubble=1 for exactly one cycle; no state change.
REQ-023 SHALL, in MUL_BUSY with Cnt!=0, drive the hold outputs of REQ-021 and decrement Cnt.
REQ-024 SHALL, in MUL_BUSY with Cnt==0, drive the REQ-017 defaults and return to RUN; the multi-cycle instruction leaves EX on this edge, giving EX occupancy of MUL_LAT cycles and MUL_LAT-1 hold cycles.
REQ-025 SHALL ignore Branch_Taken, Mul_Start and LU in MUL_BUSY.
REQ-026 SHALL increment Stall_Cnt on every edge where PC_Write=0, holding at 16'hFFFF.

Reset
REQ-027 SHALL, on any edge with Rst=1, set the state to RUN, Cnt to 0 and Stall_Cnt to 0.
REQ-028 SHALL, while Rst=1, force the outputs to the REQ-017 defaults and Mul_Busy to 0, regardless of the other inputs.
REQ-029 SHALL, if Rst is asserted in MUL_BUSY, abandon the hold and be in RUN after that edge.

Structure
REQ-030 SHALL place the state encoding (RUN=1'b0, MUL_BUSY=1'b1) and the register-index width (5) in a shared package.
REQ-031 SHALL implement the Stall_Cnt logic as one sub-module, sat_counter, parameterised by width.

Verification
REQ-032 SHALL check: load r8 in EX (IDEX_MemRead=1, IDEX_Rt=8), IFID_Rs=8 -> one cycle with PC_Write=0, IDEX_Bubble=1; Stall_Cnt=1.
REQ-033 SHALL check: same as REQ-032 but IDEX_Rt=0 -> no stall; outputs at defaults.
REQ-034 SHALL check: Mul_Start=1 with MUL_LAT=4 -> 3 consecutive hold cycles with EXMEM_Bubble=1, Mul_Busy high for 3 cycles, then RUN; Stall_Cnt=3.
REQ-035 SHALL check: Branch_Taken=1 together with Mul_Start=1 and LU -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; state stays RUN.
REQ-036 SHALL check: Rst=1 during the 2nd MUL_BUSY cycle -> defaults that cycle, RUN and Stall_Cnt=0 after the edge.
REQ-037 SHALL check: Stall_Cnt preloaded by stimulus to 16'hFFFE, then 3 stall cycles -> Stall_Cnt=16'hFFFF, no wrap.
